// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : 2-wide physical-register free list with a retirement-committed
//            read pointer so a mispredict returns all in-flight tags at once.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
   parameter int PREG_NUMBER     = 64,
   parameter int ARCH_REG_NUMBER = 32,
   parameter int FL_SIZE         = PREG_NUMBER - ARCH_REG_NUMBER
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        dispatch_en_i,
   input  logic                                        dispatch_size_i,
   input  logic [1:0]                                  retire_en_i,
   input  logic [1:0][$clog2(PREG_NUMBER)-1:0]         T_old_i,
   input  logic                                        branch_mispredicted_i,
   output logic [1:0][$clog2(PREG_NUMBER)-1:0]         freeReg_o,
   output logic [1:0]                                  free_avail_o,
   output logic                                        alloc_ack_o
`ifdef DEBUG
   ,
   output logic [$clog2(FL_SIZE):0]                    spec_head_debug,
   output logic [$clog2(FL_SIZE):0]                    ret_head_debug,
   output logic [$clog2(FL_SIZE):0]                    tail_debug,
   output logic [FL_SIZE-1:0][$clog2(PREG_NUMBER)-1:0] entries_debug
`endif
);

   localparam int c_TAG_W = $clog2(PREG_NUMBER);
   localparam int c_IDX_W = $clog2(FL_SIZE);
   localparam int c_PTR_W = c_IDX_W + 1;
   localparam int c_SUM_W = c_IDX_W + 1;
   localparam int c_CNT_W = c_IDX_W + 1;

   logic [c_TAG_W-1:0] r_entries [FL_SIZE];
   logic [c_PTR_W-1:0] r_spec_head;
   logic [c_PTR_W-1:0] r_ret_head;
   logic [c_PTR_W-1:0] r_tail;

   logic [c_CNT_W-1:0] w_count;
   logic [1:0]         w_ret_n;
   logic [1:0]         w_disp_n;
   logic [c_PTR_W-1:0] w_ret_head_next;
   logic [c_PTR_W-1:0] w_tail_next;
   logic [c_PTR_W-1:0] w_spec_head_next;
   logic [c_PTR_W-1:0] w_wr_ptr [2];
   logic [c_IDX_W-1:0] w_head_p1_idx;

   // Pointer advance: index wraps modulo FL_SIZE, the top bit flips on wrap.
   function automatic logic [c_PTR_W-1:0] ptr_add(input logic [c_PTR_W-1:0] p,
                                                  input logic [1:0]         n);
      logic [c_SUM_W-1:0] sum;
      logic [c_PTR_W-1:0] res;
      sum = {1'b0, p[c_IDX_W-1:0]} + c_SUM_W'(n);
      if (sum >= c_SUM_W'(FL_SIZE))
         res = {~p[c_PTR_W-1], c_IDX_W'(sum - c_SUM_W'(FL_SIZE))};
      else
         res = {p[c_PTR_W-1], sum[c_IDX_W-1:0]};
      return res;
   endfunction

   function automatic logic [c_CNT_W-1:0] ptr_dist(input logic [c_PTR_W-1:0] hi,
                                                   input logic [c_PTR_W-1:0] lo);
      logic [c_CNT_W-1:0] d;
      d = c_CNT_W'(hi[c_IDX_W-1:0]) - c_CNT_W'(lo[c_IDX_W-1:0]);
      if (hi[c_PTR_W-1] != lo[c_PTR_W-1])
         d = d + c_CNT_W'(FL_SIZE);
      return d;
   endfunction

   always_comb begin
      w_count       = ptr_dist(r_tail, r_spec_head);
      w_ret_n       = {1'b0, retire_en_i[0]} + {1'b0, retire_en_i[1]};
      w_head_p1_idx = (r_spec_head[c_IDX_W-1:0] == c_IDX_W'(FL_SIZE - 1)) ?
                      '0 : r_spec_head[c_IDX_W-1:0] + c_IDX_W'(1);

      alloc_ack_o = 1'b0;
      w_disp_n    = 2'd0;
      if (dispatch_en_i && !branch_mispredicted_i) begin
         if (dispatch_size_i && (w_count >= c_CNT_W'(2))) begin
            alloc_ack_o = 1'b1;
            w_disp_n    = 2'd2;
         end else if (!dispatch_size_i && (w_count >= c_CNT_W'(1))) begin
            alloc_ack_o = 1'b1;
            w_disp_n    = 2'd1;
         end
      end

      w_wr_ptr[0]     = r_tail;
      w_wr_ptr[1]     = ptr_add(r_tail, 2'd1);
      w_tail_next     = ptr_add(r_tail, w_ret_n);
      w_ret_head_next = ptr_add(r_ret_head, w_ret_n);
      // A squash rewinds to the committed pointer including this cycle's retires.
      w_spec_head_next = branch_mispredicted_i ? w_ret_head_next
                                               : ptr_add(r_spec_head, w_disp_n);

      freeReg_o[0] = r_entries[r_spec_head[c_IDX_W-1:0]];
      freeReg_o[1] = r_entries[w_head_p1_idx];

      if (w_count >= c_CNT_W'(2))
         free_avail_o = 2'd2;
      else
         free_avail_o = w_count[1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FL_SIZE; i++)
            r_entries[i] <= c_TAG_W'(ARCH_REG_NUMBER + i);
         r_spec_head <= '0;
         r_ret_head  <= '0;
         r_tail      <= {1'b1, {c_IDX_W{1'b0}}};
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (retire_en_i[k])
               r_entries[w_wr_ptr[k][c_IDX_W-1:0]] <= T_old_i[k];
         end
         r_spec_head <= w_spec_head_next;
         r_ret_head  <= w_ret_head_next;
         r_tail      <= w_tail_next;
      end
   end

`ifdef DEBUG
   always_comb begin
      spec_head_debug = r_spec_head;
      ret_head_debug  = r_ret_head;
      tail_debug      = r_tail;
      for (int i = 0; i < FL_SIZE; i++)
         entries_debug[i] = r_entries[i];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (retire_en_i != 2'b10)
            else $error("free_list: illegal retire pattern 10");
         assert (ptr_dist(w_tail_next, w_ret_head_next) <= c_CNT_W'(FL_SIZE))
            else $error("free_list: tail passed ret_head + FL_SIZE");
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/free_list.md
Name: free_list

Overview:
- 2-wide physical-register free list for the R10K-style rename path.
- Supplies new destination tags to dispatch; these become the ROB `freeReg_i` and the map-table update.
- Reclaims `T_old` tags from ROB retirement (`T_old_o` / `retire_en_o`).
- Keeps a retirement-committed read pointer so a branch misprediction restores every tag handed to squashed instructions in one cycle.

Parameters:
- PREG_NUMBER, 64, total physical registers; tag width is $clog2(PREG_NUMBER).
- ARCH_REG_NUMBER, 32, architectural registers mapped at reset.
- FL_SIZE, PREG_NUMBER-ARCH_REG_NUMBER, free list capacity in entries.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- dispatch_en_i  in  1  dispatch requests tags this cycle
- dispatch_size_i  in  1  0 = one tag, 1 = two tags
- retire_en_i  in  2  from ROB `retire_en_o`; only patterns 00, 01 and 11 are legal
- T_old_i  in  2x$clog2(PREG_NUMBER)  from ROB `T_old_o`; tags being freed
- branch_mispredicted_i  in  1  squash all unretired instructions
- freeReg_o  out  2x$clog2(PREG_NUMBER)  [0] = oldest free tag, [1] = next free tag
- free_avail_o  out  2  0 = none, 1 = exactly one, 2 = two or more
- alloc_ack_o  out  1  the dispatch request was accepted this cycle

Behaviour:
- Storage and pointers:
  - Circular array of FL_SIZE tags.
  - Pointers carry an extra wrap bit: spec_head (dispatch read), ret_head (committed read), tail (write).
  - Available count = tail - spec_head, modulo 2*FL_SIZE.
- Reset (sync, on posedge while reset is high):
  - array[i] = ARCH_REG_NUMBER+i.
  - spec_head = ret_head = 0; tail = 0 with wrap bit set (list full).
  - Post-reset outputs: freeReg_o = {33,32}, free_avail_o = 2, alloc_ack_o = 0.
  - Reset asserted mid-operation discards all state identically.
- Outputs:
  - freeReg_o[0] = array[spec_head] and freeReg_o[1] = array[spec_head+1 mod FL_SIZE], both combinational.
  - Unused slots still show the array contents; consumers qualify them with free_avail_o.
- Dispatch:
  - Accepted only when the count ≥ 1 (size 0) or ≥ 2 (size 1), and branch_mispredicted_i = 0.
  - No partial allocation.
  - On accept: spec_head += 1 or 2 at the edge; alloc_ack_o = 1, combinational.
  - On reject: no state change; alloc_ack_o = 0.
- Retire:
  - Per asserted retire_en_i[k], write T_old_i[k] at tail+k and advance tail by popcount.
  - ret_head advances by the same popcount, since every dispatched instruction consumed exactly one tag.
  - Overflow is impossible by invariant; an assertion fires under DEBUG if tail would pass ret_head+FL_SIZE.
- No bypass: tags freed this cycle are not visible in freeReg_o or the count until the next cycle.
- Mispredict:
  - spec_head ← ret_head after this cycle's retire update, i.e. all in-flight allocations are returned.
  - Same-cycle retirements still write their T_old tags.
  - Dispatch that cycle is rejected.
- Simultaneous dispatch and retire in one cycle: both apply, and the count changes by the net amount.
- Wrap-around: all pointer arithmetic is modulo FL_SIZE on the index, with the wrap bit toggling on crossing.
- Full/empty:
  - Empty: count 0, free_avail_o = 0.
  - Full: count = FL_SIZE, which is reachable only when no instructions are in flight.
- DEBUG ports (spec_head_debug, ret_head_debug, tail_debug, entries_debug) exist under `ifdef DEBUG` for the visual debugger.

Test Plan:
- Reset then dispatch size 1 -> freeReg_o = {33,32} before the edge, alloc_ack_o = 1; next cycle freeReg_o = {35,34}, count 30.
- Retire 11 with T_old = {2,1} after two dispatches -> count unchanged (net 0 for 2 out, 2 in); after 15 more size-1 dispatches the list delivers tag 1 then tag 2, in order, after the remaining 63.
- Drain to count 1, dispatch size 1 -> alloc_ack_o = 0, spec_head unchanged, free_avail_o = 1; then size 0 -> accepted, free_avail_o = 0.
- Dispatch 5 single tags (32..36), retire 01 with T_old = 7, assert mispredict -> next cycle freeReg_o[0] = 33, count = 32 - 1 + 1 = 32 - (retired allocations) + freed, i.e. every tag from 33 onward is returned.
- Mispredict with dispatch_en_i = 1 in the same cycle -> alloc_ack_o = 0, no tag consumed.
- Run 40 cycles of alternating 2-wide dispatch and 2-wide retire -> indices wrap past FL_SIZE-1, freeReg_o follows FIFO order of the freed tags, count stays constant.
- Assert reset mid-run -> next cycle state matches the reset values listed in Behaviour.
